serial_adder_seq: RTL

// Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in one bit
// per clock, LSB first, through a single full-adder slice built from two

---
 rtl/serial_adder_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder slice built from two half adders processes
// one operand bit per clock, LSB first, under a start/busy/done handshake.

module half_adder_structural (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  // Only the upper WIDTH-1 accumulator bits ever reach the result, so the
  // dropped LSB is not stored; {s, acc} is the full shifted value.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] shifted;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             ha1_s, ha1_c, ha2_s, ha2_c;
  logic             s, co;

  half_adder_structural u_ha1 (.x(sa[0]), .y(sb[0]), .s(ha1_s), .c(ha1_c));
  half_adder_structural u_ha2 (.x(ha1_s), .y(c),     .s(ha2_s), .c(ha2_c));

  assign s       = ha2_s;
  assign co      = ha1_c | ha2_c;
  assign shifted = {s, acc};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
      acc <= '0;
    end else if (state == ADD) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= shifted[WIDTH-1:1];
      c   <= co;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum  <= shifted;
        cout <= co;
      end
    end
  end
endmodule
